// File: rtl/serial_add_seq.sv
// Bit-serial adder: streams two WIDTH-bit operands LSB-first through one full-adder cell.
// Define SERIAL_ADD_OVF_EN to add the signed-overflow output ovf_o.

module switch_full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);
  assign sum_o  = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));
endmodule

module serial_add_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf_o
`endif
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic             cout_q;
  logic             busy_q;
  logic             done_q;
  logic             cell_sum;
  logic             cell_cout;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q;
`endif

  switch_full_adder u_cell (
    .a_i    (a_q[0]),
    .b_i    (b_q[0]),
    .cin_i  (carry_q),
    .sum_o  (cell_sum),
    .cout_o (cell_cout)
  );

  // Sequencer: load in IDLE, one bit per edge in RUN, single-cycle DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            a_q     <= a_i;
            b_q     <= b_i;
            carry_q <= cin_i;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_q   <= {cell_sum, sum_q[WIDTH-1:1]};
          carry_q <= cell_cout;
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LAST_BIT) begin
            cout_q  <= cell_cout;
`ifdef SERIAL_ADD_OVF_EN
            // carry_q is the carry into the MSB on this edge
            ovf_q   <= carry_q ^ cell_cout;
`endif
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign sum_o  = sum_q;
  assign cout_o = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf_o  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_seq.sv
// Directed bench for serial_add_seq: WIDTH=8 and WIDTH=2 instances on a shared clock/reset.
// Optional ovf_o checks when SERIAL_ADD_OVF_EN is defined.

module tb_serial_add_seq;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;

  logic       start2;
  logic [1:0] a2;
  logic [1:0] b2;
  logic       cin2;
  logic       busy2;
  logic       done2;
  logic [1:0] sum2;
  logic       cout2;
`ifdef SERIAL_ADD_OVF_EN
  logic       ovf;
  logic       ovf2;
`endif

  int n_vec;
  int n_err;

  serial_add_seq #(.WIDTH(8)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .start_i (start),
    .a_i     (a),
    .b_i     (b),
    .cin_i   (cin),
    .busy_o  (busy),
    .done_o  (done),
    .sum_o   (sum),
    .cout_o  (cout)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf_o   (ovf)
`endif
  );

  serial_add_seq #(.WIDTH(2)) u_dut_w2 (
    .clk     (clk),
    .rst     (rst),
    .start_i (start2),
    .a_i     (a2),
    .b_i     (b2),
    .cin_i   (cin2),
    .busy_o  (busy2),
    .done_o  (done2),
    .sum_o   (sum2),
    .cout_o  (cout2)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf_o   (ovf2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One full add on the WIDTH=8 instance with 1-cycle start; operands are scrambled after E0
  task automatic run_add(input logic [7:0] av, input logic [7:0] bv, input logic ci,
                         input logic [7:0] es, input logic ec, input logic eo);
    int bad;
    bad = 0;
    @(negedge clk);
    a = av; b = bv; cin = ci; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = ~av; b = ~bv; cin = ~ci;
    check("busy_after_e0", 32'(busy), 32'd1);
    for (int k = 1; k < 8; k++) begin
      @(posedge clk); #1;
      if (done || !busy) bad++;
    end
    check("run_window", 32'(bad), 32'd0);
    @(posedge clk); #1;
    check("done_at_e8", 32'(done), 32'd1);
    check("busy_off_e8", 32'(busy), 32'd0);
    check("sum", 32'(sum), 32'(es));
    check("cout", 32'(cout), 32'(ec));
`ifdef SERIAL_ADD_OVF_EN
    check("ovf", 32'(ovf), 32'(eo));
`else
    if (eo === 1'bx) $display("unexpected x in ovf expectation");
`endif
    @(posedge clk); #1;
    check("done_one_cycle", 32'(done), 32'd0);
    check("sum_hold", 32'(sum), 32'(es));
  endtask

  initial begin
    int ndone;
    int first_e;
    int last_e;
    int overlap;
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_w2_sum", 32'(sum2), 32'd0);
    check("rst_w2_busy", 32'(busy2), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
    check("rst_ovf", 32'(ovf), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    run_add(8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0, 1'b1);
    run_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_add(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);
    run_add(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run_add(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    run_add(8'h40, 8'h20, 1'b0, 8'h60, 1'b0, 1'b0);

    // start held high: accepts at edges 0, 10, 20; dones after edges 8, 18, 28
    ndone = 0; first_e = -1; last_e = -1; overlap = 0;
    @(negedge clk);
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (busy && done) overlap++;
      if (done) begin
        ndone++;
        if (first_e < 0) first_e = i;
        last_e = i;
        check("held_sum", 32'(sum), 32'h30);
      end
      if (i == 29) start = 1'b0;
    end
    check("held_done_count", 32'(ndone), 32'd3);
    check("held_first_done", 32'(first_e), 32'd8);
    check("held_last_done", 32'(last_e), 32'd28);
    check("held_overlap", 32'(overlap), 32'd0);

    // async reset mid-add aborts with no done
    @(negedge clk);
    a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done || busy) ndone++;
    end
    check("abort_no_done", 32'(ndone), 32'd0);
    run_add(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);

    // WIDTH=2 instance: 3+3+1 = 7 -> sum 3, cout 1
    @(negedge clk);
    a2 = 2'd3; b2 = 2'd3; cin2 = 1'b1; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0; a2 = 2'd0; b2 = 2'd0; cin2 = 1'b0;
    check("w2_busy_e0", 32'(busy2), 32'd1);
    @(posedge clk); #1;
    check("w2_no_done_e1", 32'(done2), 32'd0);
    @(posedge clk); #1;
    check("w2_done_e2", 32'(done2), 32'd1);
    check("w2_busy_off", 32'(busy2), 32'd0);
    check("w2_sum", 32'(sum2), 32'd3);
    check("w2_cout", 32'(cout2), 32'd1);
`ifdef SERIAL_ADD_OVF_EN
    check("w2_ovf", 32'(ovf2), 32'd0);
`endif
    @(posedge clk); #1;
    check("w2_done_clear", 32'(done2), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
